// File: rtl/pc_predict_unit.sv
// Fetch-stage PC generator with a direct-mapped BTB of 2-bit saturating
// counters. Holds the fetch PC, predicts taken branches combinationally from
// the current PC, honours stall/redirect from later stages, and trains the
// BTB from resolved control transfers.
module pc_predict_unit #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = 'h0000_3000,
   parameter int                BTB_DEPTH = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc4,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target
);

   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam int TGT_W = ADDR_W - 2;

   // BTB storage; valid/ctr are reset, tag/target are not
   logic             valid_q [BTB_DEPTH];
   logic [1:0]       ctr_q   [BTB_DEPTH];
   logic [TAG_W-1:0] tag_q   [BTB_DEPTH];
   logic [TGT_W-1:0] tgt_q   [BTB_DEPTH];

   logic [ADDR_W-1:0] pc_q, pc_d;

   // Low two bits of every incoming address are don't-care
   logic unused_lsbs;
   assign unused_lsbs = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

   // Lookup on the current PC
   logic [IDX_W-1:0] l_idx;
   logic [TAG_W-1:0] l_tag;
   logic             l_hit;

   assign l_idx       = pc_q[IDX_W+1:2];
   assign l_tag       = pc_q[ADDR_W-1:IDX_W+2];
   assign l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
   assign pc          = pc_q;
   assign pc4         = pc_q + ADDR_W'(4);
   assign pred_taken  = l_hit && ctr_q[l_idx][1];
   assign pred_target = l_hit ? {tgt_q[l_idx], 2'b00} : pc4;

   // Training-side lookup on the resolved PC
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic [1:0]       u_ctr;
   logic [1:0]       u_ctr_d;

   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_ctr = ctr_q[u_idx];

   // Saturating counter step for a hit
   always_comb begin
      u_ctr_d = u_ctr;
      if (upd_taken) begin
         if (u_ctr != 2'b11) u_ctr_d = u_ctr + 2'd1;
      end else begin
         if (u_ctr != 2'b00) u_ctr_d = u_ctr - 2'd1;
      end
   end

   // Next-PC select: redirect beats stall, stall beats prediction
   always_comb begin
      pc_d = pc4;
      if (redirect_valid)  pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (stall)      pc_d = pc_q;
      else if (pred_taken) pc_d = pred_target;
   end

   // PC register
   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   // Valid bits and counters: cleared on reset, trained otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (upd_valid) begin
         if (u_hit) begin
            ctr_q[u_idx] <= u_ctr_d;
         end else if (upd_taken) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= 2'b10;
         end
      end
   end

   // Tag/target written on any taken training; on a hit the tag is rewritten unchanged
   always_ff @(posedge clk) begin
      if (!reset && upd_valid && upd_taken) begin
         tag_q[u_idx] <= u_tag;
         tgt_q[u_idx] <= upd_target[ADDR_W-1:2];
      end
   end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit (BTB_DEPTH=4 so aliasing is easy to reach).
// A behavioural model predicts post-edge outputs, which are queued when
// stimulus is driven and compared once the DUT has clocked.
module tb_pc_predict_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset, stall, redirect_valid, upd_valid, upd_taken;
   logic [31:0] redirect_pc, upd_pc, upd_target;
   logic [31:0] pc, pc4, pred_target;
   logic        pred_taken;

   always #5 clk = ~clk;

   pc_predict_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_3000),
      .BTB_DEPTH(DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_taken     (upd_taken),
      .upd_target    (upd_target),
      .pc            (pc),
      .pc4           (pc4),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic        pt;
      logic [31:0] tgt;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // Reference BTB: index pc[3:2], tag = pc >> 4
   bit          m_v   [DEPTH];
   logic [31:0] m_tag [DEPTH];
   logic [31:0] m_tgt [DEPTH];
   int          m_ctr [DEPTH];
   logic [31:0] m_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void m_look(input logic [31:0] p, output logic t, output logic [31:0] tg);
      int i;
      bit h;
      i  = int'(p[3:2]);
      h  = m_v[i] && (m_tag[i] == (p >> 4));
      t  = h && (m_ctr[i] >= 2);
      tg = h ? m_tgt[i] : p + 32'd4;
   endfunction

   task automatic step(input bit rst, input bit stl, input bit rv, input logic [31:0] rpc,
                       input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
      logic        t;
      logic [31:0] tg, np;
      exp_t        e;
      int          i;
      @(negedge clk);
      reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rpc;
      upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
      m_look(m_pc, t, tg);
      if (rst)      np = 32'h3000;
      else if (rv)  np = rpc & ~32'h3;
      else if (stl) np = m_pc;
      else if (t)   np = tg;
      else          np = m_pc + 32'd4;
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            m_v[k] = 1'b0;
            m_ctr[k] = 1;
         end
      end else if (uv) begin
         i = int'(upc[3:2]);
         if (m_v[i] && m_tag[i] == (upc >> 4)) begin
            if (ut) begin
               m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               m_tgt[i] = utg & ~32'h3;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (ut) begin
            m_v[i] = 1'b1; m_tag[i] = upc >> 4; m_tgt[i] = utg & ~32'h3; m_ctr[i] = 2;
         end
      end
      m_pc = np;
      m_look(np, t, tg);
      e.pc = np; e.pt = t; e.tgt = tg;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk("sb_pc",  pc,          e.pc);
      chk("sb_pc4", pc4,         e.pc + 32'd4);
      chk("sb_pt",  pred_taken,  e.pt);
      chk("sb_tgt", pred_target, e.tgt);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic redir(input logic [31:0] a);
      step(0, 0, 1, a, 0, 0, 0, 0);
   endtask

   // Train while stalled so the PC stays put
   task automatic train(input logic [31:0] a, input bit tk, input logic [31:0] tg);
      step(0, 1, 0, 0, 1, a, tk, tg);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      m_pc = '0;

      // Reset with a training request that must be dropped
      step(1, 0, 0, 0, 1, 32'h3000, 1, 32'h3300);
      chk("rst_pc",  pc,          32'h3000);
      chk("rst_pc4", pc4,         32'h3004);
      chk("rst_pt",  pred_taken,  0);
      chk("rst_tgt", pred_target, 32'h3004);

      // Free run
      idle(); idle(); idle();
      chk("free_pc", pc, 32'h300C);

      // Train taken and restart fetch in the same cycle
      step(0, 0, 1, 32'h3000, 1, 32'h3008, 1, 32'h3100);
      idle(); idle();
      chk("hit_pc",  pc,          32'h3008);
      chk("hit_pt",  pred_taken,  1);
      chk("hit_tgt", pred_target, 32'h3100);
      idle();
      chk("follow_pc", pc, 32'h3100);

      // Two not-taken trains: 2 -> 1 -> 0
      step(0, 0, 0, 0, 1, 32'h3008, 0, 0);
      step(0, 0, 0, 0, 1, 32'h3008, 0, 0);
      redir(32'h3008);
      chk("nt_pt", pred_taken, 0);
      idle();
      chk("nt_pc", pc, 32'h300C);

      // Floor at 0: one more not-taken, then one taken leaves ctr = 1
      train(32'h3008, 0, 0);
      train(32'h3008, 1, 32'h3100);
      redir(32'h3008);
      chk("floor_pt", pred_taken, 0);

      // Ceiling at 3: four taken then one not-taken stays predicted taken
      train(32'h3008, 1, 32'h3100);
      train(32'h3008, 1, 32'h3100);
      train(32'h3008, 1, 32'h3100);
      train(32'h3008, 1, 32'h3100);
      train(32'h3008, 0, 0);
      redir(32'h3008);
      chk("sat_pt", pred_taken, 1);

      // Redirect beats stall; low bits dropped
      step(0, 1, 1, 32'h4003, 0, 0, 0, 0);
      chk("rs_pc", pc, 32'h4000);
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 0, 0, 0, 0, 0, 0);
         chk("stall_pc", pc, 32'h4000);
      end

      // Aliasing at index 0
      train(32'h3000, 1, 32'h3200);
      redir(32'h3010);
      chk("alias_miss", pred_taken, 0);
      step(0, 0, 1, 32'h3000, 1, 32'h3010, 1, 32'h3300);
      chk("alias_repl", pred_taken, 0);
      redir(32'h3010);
      chk("alias_pt",  pred_taken,  1);
      chk("alias_tgt", pred_target, 32'h3300);

      // Wrap around
      redir(32'hFFFF_FFFC);
      chk("wrap_pc4", pc4, 32'h0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("wrap_pc", pc, 32'h0);

      // Reset during stall+redirect+training
      step(1, 1, 1, 32'h5000, 1, 32'h3010, 1, 32'h3400);
      chk("rst2_pc", pc, 32'h3000);
      redir(32'h3010);
      chk("rst2_pt10", pred_taken, 0);
      redir(32'h3008);
      chk("rst2_pt08", pred_taken, 0);

      // Random mix over a small address window
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a, b, c;
         a = 32'h3000 + {$urandom_range(0, 15), 2'b00};
         b = 32'h3000 + {$urandom_range(0, 15), 2'b00};
         c = 32'h3000 + {$urandom_range(0, 15), 2'b00};
         step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), a,
              ($urandom_range(0, 1) == 1), b, ($urandom_range(0, 2) != 0), c);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Fetch-stage program-counter generator for the pipelined CPU, successor to the combinational next-PC logic. It holds the PC register and looks up a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch can follow predicted-taken branches. It accepts stall and redirect requests from later stages and trains the BTB from resolved control transfers.

## Interface

Parameters:
- ADDR_W, 32, PC width in bits (≥ 8).
- RESET_PC, 32'h0000_3000, PC value loaded on reset; bits [1:0] are 0.
- BTB_DEPTH, 64, number of BTB entries; power of two, 4..1024.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC (fetch stalled).
- redirect_valid  in  1  force the next PC. Used on mispredict, jr/jalr, or an unpredicted j/jal.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
- upd_valid  in  1  a resolved control transfer trains the BTB this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  ADDR_W  resolved target; bits [1:0] forced to 0.
- pc  out  ADDR_W  current fetch PC (register).
- pc4  out  ADDR_W  pc + 4.
- pred_taken  out  1  BTB predicts taken for pc.
- pred_target  out  ADDR_W  predicted target; valid when pred_taken = 1.

## Operation

- IDX_W = log2(BTB_DEPTH). The index is pc[IDX_W+1:2]. The tag is pc[ADDR_W-1:IDX_W+2].
- Each entry holds: valid, tag, target[ADDR_W-1:2], ctr[1:0].
- Lookup is combinational on pc:
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = {target, 2'b00}. When there is no hit, it drives pc4.
- Next-PC priority, highest first:
  1. reset → RESET_PC
  2. redirect_valid → {redirect_pc[ADDR_W-1:2], 2'b00}. This wins over stall.
  3. stall → pc (hold)
  4. pred_taken → pred_target
  5. otherwise → pc4
- Arithmetic: pc4 = pc + 4, modulo 2^ADDR_W. 0xFFFF_FFFC wraps to 0x0000_0000.
- Training is applied at the entry indexed by upd_pc, when upd_valid = 1:
  - Tag hit, taken: ctr saturating-increments (max 3) and target is overwritten with upd_target.
  - Tag hit, not taken: ctr saturating-decrements (min 0); target is unchanged.
  - Miss or invalid entry, taken: allocate the entry (valid=1, tag, target, ctr=2'b10). Any existing entry is replaced.
  - Miss, not taken: no change.
- Training is independent of stall and redirect. The same cycle may carry training and a redirect.
- There is no decode in this block. It never distinguishes jump from branch; the later stages decide what to train.

## Timing

- While reset = 1, the next edge sets:
  - pc = RESET_PC,
  - every valid = 0 and every ctr = 2'b01,
  - any upd_valid in that cycle is dropped.
- After reset, outputs are pc = RESET_PC, pc4 = RESET_PC+4, pred_taken = 0, pred_target = RESET_PC+4.
- Tags and targets are not reset.
- pc changes only on the rising edge. Lookup outputs settle combinationally in the same cycle as pc.
- Training latency is one cycle: a write at edge N is visible to lookups from cycle N+1 onward.
- A lookup and a training write to the same index in the same cycle: the lookup returns the old entry contents.
- Redirect latency is one cycle: redirect_pc is on pc the cycle after redirect_valid is sampled.
- stall with no redirect holds pc and leaves the lookup outputs unchanged (the table is unchanged unless training occurs).
- Reset asserted mid-operation (during stall or redirect) overrides everything on that edge.

## Test plan

- Reset, then 4 free-running cycles, no training → pc = 0x3000, 0x3004, 0x3008, 0x300C; pred_taken = 0 throughout.
- Train upd_pc=0x3008, upd_taken=1, upd_target=0x3100, then restart fetch from 0x3000 via redirect → at pc=0x3008 pred_taken = 1 (ctr = 2); next pc = 0x3100.
- Train the same PC not-taken twice → ctr 2→1→0; pred_taken = 0 at 0x3008; next pc = 0x300C. A third not-taken train keeps ctr = 0. Four taken trains saturate ctr at 3.
- stall=1 and redirect_valid=1 with redirect_pc=0x4003 in the same cycle → next pc = 0x4000. stall alone for 3 cycles → pc held.
- Aliasing with BTB_DEPTH=4: train 0x3000 taken, then lookup 0x3010 (same index, different tag) → miss, pred_taken = 0. Training 0x3010 taken replaces the 0x3000 entry.
- Wrap and reset: redirect to 0xFFFFFFFC → next pc = 0x00000000. Asserting reset with upd_valid=1 → table invalid afterwards and pc = 0x3000.
